// File: rtl/neopx_frame_sched_if.sv
// Wishbone classic write-master bundle between the frame scheduler and wb_neoPx.
// The master drives address, data and control signals. The slave returns ack and err.
interface neopx_frame_sched_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/neopx_frame_sched.sv
// Frame refresh sequencer for wb_neoPx. It copies a host-loaded shadow pixel buffer into
// the peripheral one Wishbone write at a time, then writes the update trigger.
module neopx_frame_sched #(
  parameter int unsigned CLK_FREQ_HZ = 72_000_000,
  parameter int unsigned FRAME_HZ    = 60,
  parameter int unsigned NUM_PIXELS  = 8,
  parameter logic [31:0] PIX_BASE    = 32'h0,
  parameter logic [31:0] TRIG_ADDR   = 32'h20,
  parameter int unsigned ACK_TIMEOUT = 255,
  localparam int unsigned IW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_force,
  input  logic                 i_pix_we,
  input  logic [IW-1:0]        i_pix_idx,
  input  logic [31:0]          i_pix_data,
  input  logic                 i_px_busy,
  neopx_frame_sched_if.master  wb,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [7:0]           o_overrun_cnt,
  output logic [7:0]           o_err_cnt
);

  localparam int unsigned DIV = (CLK_FREQ_HZ / FRAME_HZ > 0) ? (CLK_FREQ_HZ / FRAME_HZ) : 1;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WR_PIX,
    S_PIX_GAP,
    S_WR_TRIG
  } state_e;

  state_e        r_state;
  logic [CW-1:0] r_tick_cnt;
  logic          r_pending;
  logic          r_dirty;
  logic [7:0]    r_overrun_cnt;
  logic [7:0]    r_err_cnt;
  logic [31:0]   r_shadow [NUM_PIXELS];
  logic [IW-1:0] r_k;
  logic [TW-1:0] r_to_cnt;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic          r_we;
  logic [3:0]    r_sel;
  logic          r_stb;
  logic          r_cyc;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_req;
  logic          w_launch;
  logic          w_pix_wr;
  logic          w_in_cycle;
  logic          w_timeout;
  logic          w_abort;
  logic [IW-1:0] w_start_idx;
  logic [31:0]   w_pix_adr;

  assign w_tick      = i_enable && (32'(r_tick_cnt) == DIV - 1);
  assign w_req       = (w_tick && r_dirty) || i_force;
  assign w_launch    = (r_state == S_IDLE) && r_pending;
  assign w_pix_wr    = i_pix_we && (32'(i_pix_idx) < NUM_PIXELS);
  assign w_in_cycle  = (r_state == S_WR_PIX) || (r_state == S_WR_TRIG);
  assign w_timeout   = (32'(r_to_cnt) == ACK_TIMEOUT - 1);
  // An error wins over a simultaneous ack. A timeout only fires if no ack arrived this cycle.
  assign w_abort     = w_in_cycle && (wb.wb_err_i || (!wb.wb_ack_i && w_timeout));
  assign w_start_idx = (r_state == S_PIX_GAP) ? (r_k + IW'(1)) : r_k;
  assign w_pix_adr   = PIX_BASE + (32'(w_start_idx) << 2);

  // NOTE: every clocked block uses non-blocking assignments so that all registers
  // update together from pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (!i_enable || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  // A request that arrives in the launch cycle merges into the frame that is starting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending     <= 1'b0;
      r_overrun_cnt <= '0;
    end else if (w_launch) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
      if (r_pending && (r_overrun_cnt != 8'hFF)) begin
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end
    end
  end

  // NOTE: the shadow buffer is reset explicitly because the host expects a dark strip
  // after reset. This means it is built from flops, not RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_PIXELS); i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_pix_wr) begin
      r_shadow[i_pix_idx] <= i_pix_data;
    end
  end

  // A host write or an aborted frame keeps dirty set, even in the launch cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dirty <= 1'b1;
    end else if (w_pix_wr || w_abort) begin
      r_dirty <= 1'b1;
    end else if (w_launch) begin
      r_dirty <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_to_cnt     <= '0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_we         <= 1'b0;
      r_sel        <= 4'h0;
      r_stb        <= 1'b0;
      r_cyc        <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_k     <= '0;
            r_state <= S_WAIT_RDY;
          end
        end

        S_WAIT_RDY: begin
          if (!i_px_busy) begin
            r_adr    <= w_pix_adr;
            r_dat    <= r_shadow[w_start_idx];
            r_we     <= 1'b1;
            r_sel    <= 4'hF;
            r_stb    <= 1'b1;
            r_cyc    <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= S_WR_PIX;
          end
        end

        S_WR_PIX, S_WR_TRIG: begin
          if (w_abort || wb.wb_ack_i) begin
            r_we  <= 1'b0;
            r_sel <= 4'h0;
            r_stb <= 1'b0;
            r_cyc <= 1'b0;
          end
          if (w_abort) begin
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_state <= S_IDLE;
          end else if (wb.wb_ack_i) begin
            if (r_state == S_WR_TRIG) begin
              r_frame_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_state <= S_PIX_GAP;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end

        // Bus is idle for exactly this one cycle between back-to-back writes.
        S_PIX_GAP: begin
          r_we     <= 1'b1;
          r_sel    <= 4'hF;
          r_stb    <= 1'b1;
          r_cyc    <= 1'b1;
          r_to_cnt <= '0;
          if (r_k == LAST_IDX) begin
            r_adr   <= TRIG_ADDR;
            r_dat   <= 32'h1;
            r_state <= S_WR_TRIG;
          end else begin
            r_k     <= w_start_idx;
            r_adr   <= w_pix_adr;
            r_dat   <= r_shadow[w_start_idx];
            r_state <= S_WR_PIX;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb.wb_adr_o    = r_adr;
  assign wb.wb_dat_o    = r_dat;
  assign wb.wb_we_o     = r_we;
  assign wb.wb_sel_o    = r_sel;
  assign wb.wb_stb_o    = r_stb;
  assign wb.wb_cyc_o    = r_cyc;
  assign o_busy         = (r_state != S_IDLE);
  assign o_frame_done   = r_frame_done;
  assign o_overrun_cnt  = r_overrun_cnt;
  assign o_err_cnt      = r_err_cnt;

endmodule
